// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT engine control path.
// Holds the sequencer state encoding and the index bit-reversal used on load.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      OUTPUT  = 2'd3
   } fft_state_t;

   localparam int MAX_LOG2N = 3;

   // Reverses the low 'width' bits of v; bits above 'width' come back as 0.
   function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                   input int width);
      logic [MAX_LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_LOG2N; i++) begin
         if (i < width) r[width-1-i] = v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational butterfly address and twiddle generator for a radix-2 DIT FFT.
// Maps (stage, pair index) to the A/B word addresses and the twiddle ROM index.
module fft_bfly_addr_gen #(
   parameter int LOG2N = 2
) (
   input  logic [1:0]       stg,
   input  logic [LOG2N-1:0] idx,
   output logic [LOG2N-1:0] bfly_addr_a,
   output logic [LOG2N-1:0] bfly_addr_b,
   output logic [LOG2N-2:0] tw_sel
);

   localparam int TW = LOG2N - 1;

   logic [LOG2N-1:0] half;
   logic [LOG2N-1:0] low;
   logic [LOG2N-1:0] a;
   logic [1:0]       tw_shift;

   always_comb begin
      half     = LOG2N'(1) << stg;
      low      = idx & (half - LOG2N'(1));
      // Insert a zero at bit position stg to get the upper-half-free A address.
      a        = ((idx >> stg) << (stg + 2'd1)) | low;
      tw_shift = 2'(LOG2N - 1) - stg;
      bfly_addr_a = a;
      bfly_addr_b = a + half;
      tw_sel      = TW'(low << tw_shift);
   end

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for the radix-2 DIT FFT: bit-reversed load, butterfly sweep,
// natural-order output under valid/ready. Emits addresses and strobes only.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int LOG2N = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             clear,
   input  logic             load_valid,
   input  logic             out_ready,
   output logic             mem_we,
   output logic [LOG2N-1:0] mem_waddr,
   output logic             bfly_en,
   output logic [LOG2N-1:0] bfly_addr_a,
   output logic [LOG2N-1:0] bfly_addr_b,
   output logic [LOG2N-2:0] tw_sel,
   output logic             out_valid,
   output logic [LOG2N-1:0] out_addr,
   output logic             busy,
   output logic             done,
   output logic             drop,
   output fft_state_t       dbg_state
);

   localparam int N      = 1 << LOG2N;
   localparam int HALF_N = N / 2;

   // Handshake: an output word transfers on a cycle where out_valid and out_ready
   // are both high with ena high; out_valid never depends on out_ready.
   fft_state_t       state;
   logic [LOG2N-1:0] idx;
   logic [1:0]       stg;
   logic             done_q;
   logic             drop_q;

   logic             in_load;
   logic             load_q;
   logic             last_idx;
   logic             last_pair;
   logic             last_stg;
   logic [LOG2N-1:0] gen_a;
   logic [LOG2N-1:0] gen_b;
   logic [LOG2N-2:0] gen_tw;

   fft_bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .stg         (stg),
      .idx         (idx),
      .bfly_addr_a (gen_a),
      .bfly_addr_b (gen_b),
      .tw_sel      (gen_tw)
   );

   always_comb begin
      in_load   = (state == IDLE) || (state == LOAD);
      load_q    = in_load && load_valid && ena && !clear;
      last_idx  = (idx == LOG2N'(N - 1));
      last_pair = (idx == LOG2N'(HALF_N - 1));
      last_stg  = (stg == 2'(LOG2N - 1));

      mem_we      = load_q;
      mem_waddr   = load_q ? LOG2N'(bitrev(MAX_LOG2N'(idx), LOG2N)) : '0;
      bfly_en     = ena && (state == COMPUTE);
      bfly_addr_a = (state == COMPUTE) ? gen_a  : '0;
      bfly_addr_b = (state == COMPUTE) ? gen_b  : '0;
      tw_sel      = (state == COMPUTE) ? gen_tw : '0;
      out_valid   = ena && (state == OUTPUT);
      out_addr    = (state == OUTPUT) ? idx : '0;
      busy        = (state != IDLE);
      done        = done_q && ena;
      drop        = drop_q && ena;
      dbg_state   = state;
   end

   // clear acts even with ena low; otherwise a low ena freezes every register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         stg    <= '0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
      end else if (clear) begin
         state  <= IDLE;
         idx    <= '0;
         stg    <= '0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         drop_q <= 1'b0;
         case (state)
            IDLE, LOAD: begin
               if (load_valid) begin
                  if (last_idx) begin
                     state <= COMPUTE;
                     idx   <= '0;
                     stg   <= '0;
                  end else begin
                     state <= LOAD;
                     idx   <= idx + LOG2N'(1);
                  end
               end
            end
            COMPUTE: begin
               drop_q <= load_valid;
               if (last_pair) begin
                  idx <= '0;
                  if (last_stg) begin
                     state <= OUTPUT;
                     stg   <= '0;
                  end else begin
                     stg <= stg + 2'd1;
                  end
               end else begin
                  idx <= idx + LOG2N'(1);
               end
            end
            OUTPUT: begin
               drop_q <= load_valid;
               if (out_ready) begin
                  if (last_idx) begin
                     state  <= IDLE;
                     idx    <= '0;
                     done_q <= 1'b1;
                  end else begin
                     idx <= idx + LOG2N'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer at N=4: load order, butterfly sweep, output
// handshake, drop, clear, ena stall and asynchronous reset.
module tb_fft_sequencer;
   import fft_pkg::*;

   localparam int LOG2N = 2;

   logic             clk;
   logic             rst_n;
   logic             ena;
   logic             clear;
   logic             load_valid;
   logic             out_ready;
   logic             mem_we;
   logic [LOG2N-1:0] mem_waddr;
   logic             bfly_en;
   logic [LOG2N-1:0] bfly_addr_a;
   logic [LOG2N-1:0] bfly_addr_b;
   logic [LOG2N-2:0] tw_sel;
   logic             out_valid;
   logic [LOG2N-1:0] out_addr;
   logic             busy;
   logic             done;
   logic             drop;
   fft_state_t       dbg_state;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];

   fft_sequencer #(.LOG2N(LOG2N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .clear       (clear),
      .load_valid  (load_valid),
      .out_ready   (out_ready),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .bfly_en     (bfly_en),
      .bfly_addr_a (bfly_addr_a),
      .bfly_addr_b (bfly_addr_b),
      .tw_sel      (tw_sel),
      .out_valid   (out_valid),
      .out_addr    (out_addr),
      .busy        (busy),
      .done        (done),
      .drop        (drop),
      .dbg_state   (dbg_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Driver / checker tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bfly(input string tag, input logic [7:0] trip);
      chk({tag, "_en"}, 32'(bfly_en), 32'd1);
      chk({tag, "_a"},  32'(bfly_addr_a), 32'(trip[7:5]));
      chk({tag, "_b"},  32'(bfly_addr_b), 32'(trip[4:2]));
      chk({tag, "_tw"}, 32'(tw_sel), 32'(trip[1:0]));
   endtask

   // Packs an expected (A, B, tw) triple as {a[2:0], b[2:0], tw[1:0]}.
   function automatic logic [7:0] trip(input int a, input int b, input int tw);
      return {3'(a), 3'(b), 2'(tw)};
   endfunction

   task automatic load_four();
      load_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      load_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] e;
      logic [4:0] rdy_seq;
      rst_n = 1'b0; ena = 1'b1; clear = 1'b0; load_valid = 1'b0; out_ready = 1'b0;

      // Reset state
      #2;
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bfly_en", 32'(bfly_en), 0);
      chk("rst_addr_b", 32'(bfly_addr_b), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      tick(); tick();
      rst_n = 1'b1;

      // Load: bit-reversed write addresses
      exp_q = '{8'd0, 8'd2, 8'd1, 8'd3};
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         #1;
         e = exp_q.pop_front();
         chk("load_we", 32'(mem_we), 1);
         chk("load_waddr", 32'(mem_waddr), 32'(e));
         chk("load_busy", 32'(busy), (i > 0) ? 32'd1 : 32'd0);
         tick();
      end
      load_valid = 1'b0;

      // Compute sweep
      exp_q = '{trip(0,1,0), trip(2,3,0), trip(0,2,0), trip(1,3,1)};
      for (int j = 0; j < 4; j++) begin
         #1;
         chk_bfly("cmp", exp_q.pop_front());
         chk("cmp_out_valid", 32'(out_valid), 0);
         tick();
      end
      chk("latency_out_valid", 32'(out_valid), 1);
      chk("latency_bfly_en", 32'(bfly_en), 0);

      // Output with out_ready 1,0,1,1,1
      rdy_seq = 5'b11101;
      exp_q = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
      for (int k = 0; k < 5; k++) begin
         out_ready = rdy_seq[k];
         #1;
         chk("out_valid", 32'(out_valid), 1);
         chk("out_addr", 32'(out_addr), 32'(exp_q.pop_front()));
         chk("out_done_early", 32'(done), 0);
         tick();
      end
      out_ready = 1'b0;
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_state", 32'(dbg_state), 32'(IDLE));
      tick();
      chk("done_clear", 32'(done), 0);

      // load_valid held high through COMPUTE
      load_four();
      load_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("drop_we", 32'(mem_we), 0);
         chk("drop_bfly_en", 32'(bfly_en), 1);
         tick();
         chk("drop_pulse", 32'(drop), 1);
      end
      load_valid = 1'b0;
      tick();
      chk("drop_end", 32'(drop), 0);
      chk("drop_out_addr", 32'(out_addr), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      out_ready = 1'b0;
      chk("drop_done", 32'(done), 1);
      tick();

      // clear with the 3rd load
      load_valid = 1'b1;
      tick(); tick();
      clear = 1'b1;
      #1;
      chk("clr_we", 32'(mem_we), 0);
      chk("clr_waddr", 32'(mem_waddr), 0);
      tick();
      clear = 1'b0; load_valid = 1'b0;
      chk("clr_state", 32'(dbg_state), 32'(IDLE));
      chk("clr_busy", 32'(busy), 0);
      exp_q = '{8'd0, 8'd2, 8'd1, 8'd3};
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         #1;
         chk("reload_we", 32'(mem_we), 1);
         chk("reload_waddr", 32'(mem_waddr), 32'(exp_q.pop_front()));
         tick();
      end
      load_valid = 1'b0;

      // ena low for 3 cycles after the first butterfly
      exp_q = '{trip(0,1,0), trip(2,3,0), trip(0,2,0), trip(1,3,1)};
      #1;
      chk_bfly("stall_pre", exp_q.pop_front());
      tick();
      ena = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("stall_bfly_en", 32'(bfly_en), 0);
         chk("stall_addr_a", 32'(bfly_addr_a), 2);
         chk("stall_state", 32'(dbg_state), 32'(COMPUTE));
         tick();
      end
      ena = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk_bfly("stall_post", exp_q.pop_front());
         tick();
      end
      chk("stall_out_valid", 32'(out_valid), 1);

      // rst_n pulsed during OUTPUT
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pre_rst_addr", 32'(out_addr), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_addr", 32'(out_addr), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_addr_a", 32'(bfly_addr_a), 0);
      chk("arst_state", 32'(dbg_state), 32'(IDLE));
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

      // Final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the radix-2 DIT FFT datapath inside `tt_um_FFT_engine`. It accepts complex samples from the pad-side load interface and writes them into the sample RAM in bit-reversed order. It then steps the shared butterfly unit through every stage and pair, and finally presents results in natural order under a valid/ready handshake. The block is pure control: it emits addresses, enables and twiddle selects, and it never touches data.

## Interface
Parameters:
- `LOG2N`, default 2: log2 of the FFT size. Supported values are 2 and 3, so N = 1<<LOG2N points.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: global enable. When low, all registers hold their value and all strobes are forced to 0.
- `clear` in 1: synchronous abort to IDLE. Takes priority over every other input.
- `load_valid` in 1: a sample is present on the datapath input this cycle.
- `out_ready` in 1: the consumer accepts the current output word.
- `mem_we` in/out: `mem_we` out 1, sample RAM write strobe for the load path.
- `mem_waddr` out LOG2N: write address for loading, equal to bitrev(sample index).
- `bfly_en` out 1: the butterfly reads A and B this cycle and writes back A' and B' on the next edge.
- `bfly_addr_a` out LOG2N: butterfly address A.
- `bfly_addr_b` out LOG2N: butterfly address B.
- `tw_sel` out LOG2N-1: twiddle ROM index k, selecting W_N^k.
- `out_valid` out 1: the output word at `out_addr` is valid.
- `out_addr` out LOG2N: RAM read address for the output, in natural order.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final output handshake.
- `drop` out 1: one-cycle pulse when `load_valid` arrives outside IDLE or LOAD.

## Operation
- States are IDLE, LOAD, COMPUTE and OUTPUT. The block has one index counter `idx` (LOG2N bits) and one stage counter `stg`.
- In IDLE and LOAD, a qualified load is `load_valid & ena & ~clear`.
  - A qualified load drives `mem_we`=1 and `mem_waddr`=bitrev(`idx`) combinationally, and `idx` increments.
  - The first qualified load moves IDLE to LOAD.
  - The load with `idx`=N-1 moves the block to COMPUTE with `idx`=0 and `stg`=0.
- COMPUTE runs one butterfly per enabled cycle, with `bfly_en`=1, for LOG2N·N/2 cycles in total.
  - For stage s and pair b: half = 1<<s, a = ((b>>s)<<(s+1)) | (b & (half-1)), `bfly_addr_b` = a + half, `tw_sel` = (b & (half-1)) << (LOG2N-1-s).
  - `idx` counts b from 0 to N/2-1. When it wraps, `stg` increments. After the last pair of stage LOG2N-1 the block moves to OUTPUT with `idx`=0.
- In OUTPUT, `out_valid`=1 and `out_addr`=`idx`.
  - `idx` advances on each cycle with `out_valid & out_ready & ena`.
  - The handshake at `idx`=N-1 moves the block to IDLE and produces a `done` pulse on the following cycle.
- `drop` pulses when `load_valid` arrives in COMPUTE or OUTPUT. The sample is ignored and no state changes.
- When `clear` is asserted, the block goes to IDLE with all counters at 0. `clear` wins over a simultaneous `load_valid` or `out_ready`, so no `mem_we` is issued that cycle and no `done` pulse follows.
- Deasserting `ena` mid-operation freezes the state. The block resumes exactly where it stopped, with no lost or repeated butterfly.

## Timing
- Reset values: state IDLE, `idx`=0, `stg`=0. Every output is 0, including `mem_waddr`, `bfly_addr_a`, `bfly_addr_b`, `tw_sel` and `out_addr`.
- `mem_we` and `mem_waddr` are Mealy outputs, so the write lands on the same edge that accepts the sample. All other outputs are Moore decodes of the registered state.
- `done` and `drop` are registered one-cycle pulses.
- Latency: the first `out_valid` appears LOG2N·N/2 cycles after the edge that accepts the last sample (4 cycles for N=4, 12 cycles for N=8).
- RAM writes from a butterfly land at the end of its `bfly_en` cycle. The pair ordering guarantees that no butterfly in stage s+1 reads a word written in the same cycle.
- Asserting `rst_n` low at any point forces the reset values immediately.

## Structure
- The shared `fft_pkg` holds the `fft_state_t` enum (IDLE, LOAD, COMPUTE, OUTPUT) and the `bitrev()` function, parameterised on LOG2N.
- Address and twiddle generation is a separate combinational sub-module, `fft_bfly_addr_gen`, with inputs `stg` and `idx` and outputs `bfly_addr_a`, `bfly_addr_b` and `tw_sel`.

## Test plan
- Load N=4 samples on consecutive cycles -> `mem_waddr` sequence 0,2,1,3, and `busy` rises after the first accepted sample.
- Compute sweep for N=4 -> (A, B, tw) sequence (0,1,0), (2,3,0), (0,2,0), (1,3,1), then `out_valid` 4 cycles after the last load edge.
- Output with `out_ready` toggled 1,0,1,1,1 -> `out_addr` sequence 0,1,1,2,3, with `done` one cycle after the handshake at addr 3 and `busy` low at the same time.
- `load_valid` held high during COMPUTE -> a `drop` pulse on each of those cycles, and `mem_we` stays 0.
- `clear` asserted together with the 3rd `load_valid` -> no write, IDLE next cycle, and a fresh load restarts at `mem_waddr`=0.
- `ena` low for 3 cycles in the middle of stage 0, and separately `rst_n` pulsed during OUTPUT -> the butterfly sequence is identical apart from the stall, and the reset case shows all outputs at 0 and state IDLE.
